clock_display_mux: RTL and testbench

- Display stage fed by the sec/min/hr timekeeping counter.
- Captures a time snapshot on a strobe and range-checks it.
- Converts each field to two BCD digits with a sequential double-dabble.
- Drives a 6-digit multiplexed common-anode 7-segment display, showing HH.MM.SS with a blinking separator.

---
 rtl/clock_display_pkg.sv | 39 +++
 rtl/bcd_dabble7.sv | 55 +++++
 rtl/clock_display_mux.sv | 171 +++++++++++++++++
 tb/tb_clock_display_mux.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared types, field limits and segment encoding for the clock display stage.
// Patterns are active-low {g,f,e,d,c,b,a}.
package clock_display_pkg;

   typedef enum logic [1:0] {StIdle, StConv, StCommit} conv_state_e;

   typedef logic [3:0] digit_t;
   localparam digit_t DASH = 4'hF;

   localparam int unsigned SEC_MAX      = 59;
   localparam int unsigned MIN_MAX      = 59;
   localparam int unsigned HR_MAX       = 23;
   localparam int unsigned NUM_DIGITS   = 6;
   localparam int unsigned DABBLE_STEPS = 7;

   // Conversion order of the captured fields
   localparam logic [1:0] FIELD_SEC = 2'd0;
   localparam logic [1:0] FIELD_MIN = 2'd1;
   localparam logic [1:0] FIELD_HR  = 2'd2;

   function automatic logic [6:0] seg_encode(input digit_t digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = 7'h40;
         4'd1:    pattern = 7'h79;
         4'd2:    pattern = 7'h24;
         4'd3:    pattern = 7'h30;
         4'd4:    pattern = 7'h19;
         4'd5:    pattern = 7'h12;
         4'd6:    pattern = 7'h02;
         4'd7:    pattern = 7'h78;
         4'd8:    pattern = 7'h00;
         4'd9:    pattern = 7'h10;
         default: pattern = 7'h3F;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/bcd_dabble7.sv
// Sequential double-dabble: 7-bit binary to two BCD digits, one shift/add-3 step per cycle.
// The first step happens on the start edge; done pulses for one cycle after the last step.
module bcd_dabble7
   import clock_display_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] value,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic [14:0] sr_q;  // {tens, ones, remaining binary}
   logic [2:0]  cnt_q;
   logic        active_q;
   logic        done_q;

   function automatic logic [14:0] dabble_step(input logic [14:0] s);
      logic [14:0] t;
      t = s;
      if (t[10:7] >= 4'd5)  t[10:7]  = t[10:7] + 4'd3;
      if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
      return {t[13:0], 1'b0};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q     <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            sr_q     <= dabble_step({8'd0, value});
            cnt_q    <= 3'd1;
            active_q <= 1'b1;
         end else if (active_q) begin
            sr_q  <= dabble_step(sr_q);
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'(DABBLE_STEPS - 1)) begin
               active_q <= 1'b0;
               done_q   <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign tens = sr_q[14:11];
   assign ones = sr_q[10:7];

endmodule

// File: rtl/clock_display_mux.sv
// Captures a time snapshot, converts it to BCD and scans it onto a 6-digit
// common-anode 7-segment display as HH.MM.SS with a blinking separator.
module clock_display_mux
   import clock_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       time_valid,
   input  logic [6:0] sec_in,
   input  logic [6:0] min_in,
   input  logic [4:0] hr_in,
   input  logic       blank,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       busy,
   output logic       overrun,
   output logic       range_err
);

   localparam int unsigned DivW = $clog2(SCAN_DIV);

   conv_state_e     state_q, state_d;
   logic [6:0]      sec_q, min_q;
   logic [4:0]      hr_q;
   logic            err_q;
   logic [1:0]      field_q;
   logic [2:0]      step_q;
   logic            dab_start, dab_done;
   logic [6:0]      dab_value;
   logic [3:0]      dab_tens, dab_ones;
   digit_t          low_q  [4];  // converted sec/min digits awaiting commit
   digit_t          disp_q [NUM_DIGITS];
   logic            overrun_q, range_err_q;
   logic [DivW-1:0] div_q;
   logic [2:0]      idx_q;
   logic [6:0]      seg_q;
   logic            dp_q;
   logic [5:0]      an_q;
   logic            sec_even;

   always_comb begin
      state_d   = state_q;
      dab_start = 1'b0;
      unique case (state_q)
         StIdle:   if (time_valid) state_d = StConv;
         StConv: begin
            dab_start = (step_q == '0);
            if (field_q == FIELD_HR && step_q == 3'(DABBLE_STEPS - 1)) state_d = StCommit;
         end
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      dab_value = sec_q;
      case (field_q)
         FIELD_SEC: dab_value = sec_q;
         FIELD_MIN: dab_value = min_q;
         FIELD_HR:  dab_value = {2'b00, hr_q};
         default:   dab_value = sec_q;
      endcase
   end

   bcd_dabble7 u_dabble (
      .clk   (clk),
      .rst   (rst),
      .start (dab_start),
      .value (dab_value),
      .done  (dab_done),
      .tens  (dab_tens),
      .ones  (dab_ones)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         sec_q       <= '0;
         min_q       <= '0;
         hr_q        <= '0;
         err_q       <= 1'b0;
         field_q     <= FIELD_SEC;
         step_q      <= '0;
         overrun_q   <= 1'b0;
         range_err_q <= 1'b0;
         low_q       <= '{default: '0};
         disp_q      <= '{default: '0};
      end else begin
         state_q   <= state_d;
         overrun_q <= time_valid && (state_q != StIdle);
         unique case (state_q)
            StIdle: begin
               if (time_valid) begin
                  sec_q   <= sec_in;
                  min_q   <= min_in;
                  hr_q    <= hr_in;
                  err_q   <= (sec_in > 7'(SEC_MAX)) || (min_in > 7'(MIN_MAX)) ||
                             (hr_in > 5'(HR_MAX));
                  field_q <= FIELD_SEC;
                  step_q  <= '0;
               end
            end
            StConv: begin
               if (step_q == 3'(DABBLE_STEPS - 1)) begin
                  step_q  <= '0;
                  field_q <= field_q + 2'd1;
               end else begin
                  step_q <= step_q + 3'd1;
               end
               // done belongs to the previous field while the next one starts
               if (dab_done) begin
                  if (field_q == FIELD_MIN) begin
                     low_q[0] <= dab_ones;
                     low_q[1] <= dab_tens;
                  end else if (field_q == FIELD_HR) begin
                     low_q[2] <= dab_ones;
                     low_q[3] <= dab_tens;
                  end
               end
            end
            StCommit: begin
               range_err_q <= err_q;
               if (err_q) begin
                  disp_q <= '{default: DASH};
               end else begin
                  disp_q[0] <= low_q[0];
                  disp_q[1] <= low_q[1];
                  disp_q[2] <= low_q[2];
                  disp_q[3] <= low_q[3];
                  disp_q[4] <= dab_ones;
                  disp_q[5] <= dab_tens;
               end
            end
            default: ;
         endcase
      end
   end

   assign sec_even = (disp_q[0] == DASH) || !disp_q[0][0];

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         idx_q <= '0;
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
         an_q  <= 6'h3F;
      end else begin
         if (div_q == DivW'(SCAN_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
         end else begin
            div_q <= div_q + DivW'(1);
         end
         an_q  <= blank ? 6'h3F : ~(6'b1 << idx_q);
         seg_q <= seg_encode(disp_q[idx_q]);
         dp_q  <= ~(((idx_q == 3'd2) || (idx_q == 3'd4)) && sec_even);
      end
   end

   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign busy      = (state_q != StIdle);
   assign overrun   = overrun_q;
   assign range_err = range_err_q;

endmodule

// File: tb/tb_clock_display_mux.sv
// Randomized bench for clock_display_mux; expectations come from a time-of-day model
// (tens/ones arithmetic, scan position derived from elapsed cycles).
module tb_clock_display_mux;

   localparam int unsigned SCAN_DIV = 4;

   logic       clk = 1'b0;
   logic       rst, time_valid, blank;
   logic [6:0] sec_in, min_in;
   logic [4:0] hr_in;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;
   logic       busy, overrun, range_err;

   int         checks = 0;
   int         errors = 0;
   int         n_edges = 0;
   logic       blank_s = 1'b0;
   int         mdl_digits [6];
   logic       mdl_range_err;
   logic [6:0] seg_tab [16];

   clock_display_mux #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .time_valid (time_valid),
      .sec_in     (sec_in),
      .min_in     (min_in),
      .hr_in      (hr_in),
      .blank      (blank),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .busy       (busy),
      .overrun    (overrun),
      .range_err  (range_err)
   );

   always #5 clk = ~clk;

   // Elapsed non-reset edges and the blank value each edge saw
   always @(posedge clk) begin
      if (rst) n_edges <= 0;
      else     n_edges <= n_edges + 1;
      blank_s <= blank;
   end

   function automatic bit out_of_range(input int s, input int m, input int h);
      return (s > 59) || (m > 59) || (h > 23);
   endfunction

   task automatic set_model(input int s, input int m, input int h);
      if (out_of_range(s, m, h)) begin
         for (int i = 0; i < 6; i++) mdl_digits[i] = 15;
         mdl_range_err = 1'b1;
      end else begin
         mdl_digits[0] = s % 10;
         mdl_digits[1] = s / 10;
         mdl_digits[2] = m % 10;
         mdl_digits[3] = m / 10;
         mdl_digits[4] = h % 10;
         mdl_digits[5] = h / 10;
         mdl_range_err = 1'b0;
      end
   endtask

   task automatic check_scan(input int cycles, input string tag);
      int         idx;
      logic [5:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         idx     = ((n_edges - 1) / SCAN_DIV) % 6;
         exp_an  = blank_s ? 6'h3F : ~(6'b1 << idx);
         exp_seg = seg_tab[mdl_digits[idx]];
         exp_dp  = !(((idx == 2) || (idx == 4)) &&
                     ((mdl_digits[0] == 15) || (mdl_digits[0] % 2 == 0)));
         checks++;
         if (an !== exp_an) begin
            errors++;
            $display("FAIL %s an: got %h want %h", tag, an, exp_an);
         end
         checks++;
         if (seg !== exp_seg) begin
            errors++;
            $display("FAIL %s seg idx %0d: got %h want %h", tag, idx, seg, exp_seg);
         end
         checks++;
         if (dp !== exp_dp) begin
            errors++;
            $display("FAIL %s dp idx %0d: got %b want %b", tag, idx, dp, exp_dp);
         end
         checks++;
         if ({busy, overrun, range_err} !== {2'b00, mdl_range_err}) begin
            errors++;
            $display("FAIL %s idle flags busy/overrun/range_err: got %b%b%b want 00%b",
                     tag, busy, overrun, range_err, mdl_range_err);
         end
      end
   endtask

   // Strobe at the current negedge, optionally firing extra strobes at cycles set in extra.
   task automatic run_conv(input int s, input int m, input int h, input logic [23:0] extra,
                           input string tag);
      logic prev_err;
      prev_err   = mdl_range_err;
      sec_in     = 7'(s);
      min_in     = 7'(m);
      hr_in      = 5'(h);
      time_valid = 1'b1;
      for (int j = 1; j <= 23; j++) begin
         @(negedge clk);
         checks++;
         if (busy !== (j <= 22)) begin
            errors++;
            $display("FAIL %s busy cycle %0d: got %b want %b", tag, j, busy, (j <= 22));
         end
         checks++;
         if (overrun !== (j >= 2 && extra[j-1])) begin
            errors++;
            $display("FAIL %s overrun cycle %0d: got %b want %b", tag, j, overrun,
                     (j >= 2 && extra[j-1]));
         end
         if (j <= 22) begin
            checks++;
            if (range_err !== prev_err) begin
               errors++;
               $display("FAIL %s range_err early cycle %0d: got %b want %b", tag, j,
                        range_err, prev_err);
            end
         end
         time_valid = (j <= 22) && extra[j];
         if (time_valid) begin
            sec_in = 7'($urandom_range(0, 127));
            min_in = 7'($urandom_range(0, 127));
            hr_in  = 5'($urandom_range(0, 31));
         end
      end
      set_model(s, m, h);
      checks++;
      if (range_err !== mdl_range_err) begin
         errors++;
         $display("FAIL %s range_err after commit: got %b want %b", tag, range_err,
                  mdl_range_err);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({seg, dp, an} !== {7'h7F, 1'b1, 6'h3F}) begin
         errors++;
         $display("FAIL reset seg/dp/an: got %h/%b/%h want 7f/1/3f", seg, dp, an);
      end
      checks++;
      if ({busy, overrun, range_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset flags: got %b%b%b want 000", busy, overrun, range_err);
      end
      for (int i = 0; i < 6; i++) mdl_digits[i] = 0;
      mdl_range_err = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_scan_idle;
      check_scan(2 * 6 * SCAN_DIV, "scan_idle");
   endtask

   task automatic test_convert;
      run_conv(58, 59, 23, 24'd0, "conv_235958");
      check_scan(30, "disp_235958");
      repeat (5) begin
         run_conv(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
                  int'($urandom_range(0, 23)), 24'd0, "conv_rand");
         check_scan(24, "disp_rand");
      end
   endtask

   task automatic test_range;
      run_conv(60, 10, 10, 24'd0, "conv_sec60");
      check_scan(24, "disp_sec60");
      run_conv(int'($urandom_range(0, 59)), int'($urandom_range(60, 127)), 5, 24'd0,
               "conv_badmin");
      check_scan(12, "disp_badmin");
      run_conv(1, 2, int'($urandom_range(24, 31)), 24'd0, "conv_badhr");
      check_scan(12, "disp_badhr");
      run_conv(3, 2, 1, 24'd0, "conv_010203");
      check_scan(24, "disp_010203");
   endtask

   task automatic test_overrun;
      run_conv(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
               int'($urandom_range(0, 23)), 24'h000020, "ovr_single");
      check_scan(24, "disp_ovr_single");
      // Back-to-back drops plus one in the commit cycle, then a strobe right as busy falls
      run_conv(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
               int'($urandom_range(0, 23)), 24'h400018, "ovr_burst");
      run_conv(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
               int'($urandom_range(0, 23)), 24'd0, "conv_chained");
      check_scan(24, "disp_chained");
   endtask

   task automatic test_blank;
      blank = 1'b1;
      check_scan(10, "blank_on");
      blank = 1'b0;
      check_scan(30, "blank_off");
   endtask

   task automatic test_reset_mid;
      sec_in     = 7'($urandom_range(60, 127));
      min_in     = 7'($urandom_range(0, 59));
      hr_in      = 5'($urandom_range(0, 23));
      time_valid = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         checks++;
         if ({busy, overrun} !== {1'b1, (j == 6)}) begin
            errors++;
            $display("FAIL rst_mid busy/overrun cycle %0d: got %b%b want 1%b", j, busy,
                     overrun, (j == 6));
         end
         time_valid = (j == 5);
         if (j == 10) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, overrun, range_err} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid flags: got %b%b%b want 000", busy, overrun, range_err);
      end
      checks++;
      if ({seg, dp, an} !== {7'h7F, 1'b1, 6'h3F}) begin
         errors++;
         $display("FAIL rst_mid seg/dp/an: got %h/%b/%h want 7f/1/3f", seg, dp, an);
      end
      for (int i = 0; i < 6; i++) mdl_digits[i] = 0;
      mdl_range_err = 1'b0;
      check_scan(40, "disp_after_rst");
   endtask

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F};
      rst        = 1'b1;
      time_valid = 1'b0;
      blank      = 1'b0;
      sec_in     = '0;
      min_in     = '0;
      hr_in      = '0;
      mdl_range_err = 1'b0;
      test_reset;
      test_scan_idle;
      test_convert;
      test_range;
      test_overrun;
      test_blank;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
